l3_polyphase_deserializer: RTL and testbench

- Upstream feeder for the 3-parallel reduced-complexity FIR.
- Takes a serial sample stream with a valid/ready handshake and packs each 3 consecutive samples into one block: lanes 1/2/3 = x(3k)/x(3k+1)/x(3k+2).
- The block is held in a registered output slot with its own valid/ready handshake, so the parallel filter is fed one complete block per accepted transfer.
- Supports flushing a partial block, zero-padded, at end of stream.

---
 rtl/l3_polyphase_deserializer_pkg.sv | 11 +
 rtl/l3_polyphase_deserializer_if.sv | 23 ++
 rtl/l3_block_slot.sv | 32 +++
 rtl/l3_polyphase_deserializer.sv | 64 ++++++
 tb/tb_l3_polyphase_deserializer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/l3_polyphase_deserializer_pkg.sv
// l3_filter_pkg: shared sample/block types and assembly phase encoding for the 3-parallel FIR datapath
package l3_filter_pkg;
  localparam int DATA_IN_WIDTH = 16;
  typedef logic signed [DATA_IN_WIDTH-1:0] sample_t;
  typedef struct packed {
    sample_t x0;
    sample_t x1;
    sample_t x2;
  } block_t;
  typedef enum logic [1:0] {PH0, PH1, PH2} phase_e;
endpackage

// File: rtl/l3_polyphase_deserializer_if.sv
// l3_polyphase_deserializer_if: serial-in / 3-lane block-out handshake bundle
// slave  : deserializer side (accepts s_*, flush, m_ready; drives s_ready, m_valid, lanes, phase)
// master : stimulus/upstream+downstream side
interface l3_polyphase_deserializer_if #(parameter int W = 16);
  logic s_valid;
  logic s_ready;
  logic signed [W-1:0] s_data;
  logic flush;
  logic m_valid;
  logic m_ready;
  logic signed [W-1:0] data_out_1;
  logic signed [W-1:0] data_out_2;
  logic signed [W-1:0] data_out_3;
  logic [1:0] phase;
  modport slave (
    input s_valid, s_data, flush, m_ready,
    output s_ready, m_valid, data_out_1, data_out_2, data_out_3, phase
  );
  modport master (
    output s_valid, s_data, flush, m_ready,
    input s_ready, m_valid, data_out_1, data_out_2, data_out_3, phase
  );
endinterface

// File: rtl/l3_block_slot.sv
// l3_block_slot: single-entry registered valid/ready holding register for one block
// clk, reset_n : clock, async active-low reset
// load, din    : write din when the slot is free
// free         : slot empty or being drained this cycle
// m_valid, m_ready, dout : downstream handshake and held block
module l3_block_slot
  import l3_filter_pkg::*;
#(
  parameter type T = block_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  T     din,
  output logic free,
  output logic m_valid,
  input  logic m_ready,
  output T     dout
);
  logic ld;
  assign free = !m_valid || m_ready;
  assign ld = load && free;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      dout <= '0;
    end else begin
      if (ld) dout <= din;
      m_valid <= ld || (m_valid && !m_ready);
    end
  end
endmodule

// File: rtl/l3_polyphase_deserializer.sv
// l3_polyphase_deserializer: packs 3 serial samples into one block (lane1 oldest), with zero-padded flush
// clk, reset_n : clock, async active-low reset
// bus.s_valid/s_ready/s_data : serial sample input handshake
// bus.flush   : pulse closing the current partial block
// bus.m_valid/m_ready/data_out_1..3 : block output handshake
// bus.phase   : samples currently held in assembly registers (debug)
module l3_polyphase_deserializer #(
  parameter int DATA_IN_WIDTH = l3_filter_pkg::DATA_IN_WIDTH
) (
  input logic clk,
  input logic reset_n,
  l3_polyphase_deserializer_if.slave bus
);
  import l3_filter_pkg::*;
  typedef logic signed [DATA_IN_WIDTH-1:0] smp_t;
  typedef struct packed {
    smp_t x0;
    smp_t x1;
    smp_t x2;
  } blk_t;
  phase_e phase, phase_nx;
  smp_t asm0, asm1;
  logic flush_pending, free, xfer, fl_ld, ld;
  blk_t blk, out_blk;
  assign bus.s_ready = !flush_pending && (phase != PH2 || free);
  assign xfer = bus.s_valid && bus.s_ready;
  // a pending flush blocks s_ready, so flush loads and PH2 completions never coincide
  assign fl_ld = flush_pending && free;
  assign ld = fl_ld || (xfer && phase == PH2);
  always_comb begin
    blk.x0 = asm0;
    blk.x1 = (fl_ld && phase != PH2) ? '0 : asm1;
    blk.x2 = fl_ld ? '0 : bus.s_data;
    phase_nx = fl_ld ? PH0 : !xfer ? phase : (phase == PH2) ? PH0 : phase_e'(phase + 2'd1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH0;
      asm0 <= '0;
      asm1 <= '0;
      flush_pending <= 1'b0;
    end else begin
      phase <= phase_nx;
      if (xfer && phase == PH0) asm0 <= bus.s_data;
      if (xfer && phase == PH1) asm1 <= bus.s_data;
      // the flush acts on the post-transfer phase; an empty result makes it a no-op
      flush_pending <= (flush_pending || bus.flush) && phase_nx != PH0;
    end
  end
  l3_block_slot #(.T(blk_t)) u_slot (
    .clk(clk),
    .reset_n(reset_n),
    .load(ld),
    .din(blk),
    .free(free),
    .m_valid(bus.m_valid),
    .m_ready(bus.m_ready),
    .dout(out_blk)
  );
  assign bus.data_out_1 = out_blk.x0;
  assign bus.data_out_2 = out_blk.x1;
  assign bus.data_out_3 = out_blk.x2;
  assign bus.phase = phase;
endmodule

// File: tb/tb_l3_polyphase_deserializer.sv
// tb_l3_polyphase_deserializer: directed and scoreboarded checks of the 3-sample block packer
module tb_l3_polyphase_deserializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int nvec = 0;
  int nerr = 0;
  l3_polyphase_deserializer_if #(.W(16)) bus ();
  l3_polyphase_deserializer #(.DATA_IN_WIDTH(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_blk(input string tag, input int a, input int b, input int c);
    chk({tag, "_mv"}, 64'(bus.m_valid), 1);
    chk({tag, "_l1"}, bus.data_out_1, a);
    chk({tag, "_l2"}, bus.data_out_2, b);
    chk({tag, "_l3"}, bus.data_out_3, c);
  endtask
  task automatic send(input int v, input logic rdy);
    bus.s_valid = 1'b1;
    bus.s_data = 16'(v);
    #1;
    chk("s_ready", 64'(bus.s_ready), 64'(rdy));
    step();
    bus.s_valid = 1'b0;
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.flush = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mv", 64'(bus.m_valid), 0);
    chk("rst_phase", 64'(bus.phase), 0);
    chk("rst_l1", bus.data_out_1, 0);
    reset_n = 1'b1;
    step();
    // streaming 1..6 with free downstream
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      send(i, 1'b1);
      if (i == 3) chk_blk("blk123", 1, 2, 3);
      else if (i == 6) chk_blk("blk456", 4, 5, 6);
      else chk("mv_gap", 64'(bus.m_valid), 0);
    end
    step();
    chk("mv_after6", 64'(bus.m_valid), 0);
    // backpressure
    bus.m_ready = 1'b0;
    send(10, 1'b1);
    send(20, 1'b1);
    send(30, 1'b1);
    chk_blk("bp_first", 10, 20, 30);
    send(40, 1'b1);
    send(50, 1'b1);
    chk_blk("bp_hold", 10, 20, 30);
    bus.s_valid = 1'b1;
    bus.s_data = 16'(60);
    #1;
    chk("bp_rdy_ph2", 64'(bus.s_ready), 0);
    step();
    chk_blk("bp_hold2", 10, 20, 30);
    chk("bp_phase", 64'(bus.phase), 2);
    bus.m_ready = 1'b1;
    #1;
    chk("bp_rdy_free", 64'(bus.s_ready), 1);
    step();
    bus.s_valid = 1'b0;
    chk_blk("bp_second", 40, 50, 60);
    chk("bp_phase0", 64'(bus.phase), 0);
    step();
    chk("bp_drained", 64'(bus.m_valid), 0);
    // flush of partial blocks
    send(-5, 1'b1);
    send(7, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl2_pend_rdy", 64'(bus.s_ready), 0);
    chk("fl2_mv0", 64'(bus.m_valid), 0);
    step();
    chk_blk("fl2_blk", -5, 7, 0);
    chk("fl2_phase", 64'(bus.phase), 0);
    step();
    send(-5, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    chk_blk("fl1_blk", -5, 0, 0);
    step();
    chk("fl1_drained", 64'(bus.m_valid), 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl0_mv", 64'(bus.m_valid), 0);
    chk("fl0_rdy", 64'(bus.s_ready), 1);
    step();
    chk("fl0_mv2", 64'(bus.m_valid), 0);
    // flush coincident with a transfer
    send(1, 1'b1);
    send(2, 1'b1);
    bus.flush = 1'b1;
    send(9, 1'b1);
    bus.flush = 1'b0;
    chk_blk("flx_blk", 1, 2, 9);
    step();
    chk("flx_noextra", 64'(bus.m_valid), 0);
    step();
    chk("flx_noextra2", 64'(bus.m_valid), 0);
    chk("flx_rdy", 64'(bus.s_ready), 1);
    send(4, 1'b1);
    bus.flush = 1'b1;
    send(8, 1'b1);
    bus.flush = 1'b0;
    chk("fly_phase", 64'(bus.phase), 2);
    chk("fly_rdy", 64'(bus.s_ready), 0);
    step();
    chk_blk("fly_blk", 4, 8, 0);
    step();
    // asynchronous reset mid-block with a held block
    bus.m_ready = 1'b0;
    send(1, 1'b1);
    send(2, 1'b1);
    send(3, 1'b1);
    send(4, 1'b1);
    chk("ar_pre_mv", 64'(bus.m_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_mv", 64'(bus.m_valid), 0);
    chk("ar_l1", bus.data_out_1, 0);
    chk("ar_l3", bus.data_out_3, 0);
    chk("ar_phase", 64'(bus.phase), 0);
    step();
    reset_n = 1'b1;
    step();
    bus.m_ready = 1'b1;
    send(1, 1'b1);
    send(2, 1'b1);
    send(3, 1'b1);
    chk_blk("ar_blk", 1, 2, 3);
    step();
    // random traffic against a scoreboard
    begin
      logic signed [15:0] q[$];
      logic signed [15:0] p1, p2, p3;
      int sent = 0;
      int got = 0;
      logic held = 1'b0;
      for (int c = 0; c < 60000 && got < 3333; c++) begin
        bus.s_valid = (sent < 9999) && ($urandom_range(3) != 0);
        bus.s_data = 16'($urandom);
        bus.m_ready = $urandom_range(2) != 0;
        @(negedge clk);
        if (held) begin
          chk("rnd_hold_mv", 64'(bus.m_valid), 1);
          chk("rnd_hold_l1", bus.data_out_1, p1);
          chk("rnd_hold_l2", bus.data_out_2, p2);
          chk("rnd_hold_l3", bus.data_out_3, p3);
        end
        if (bus.s_valid && bus.s_ready) begin
          q.push_back(bus.s_data);
          sent++;
        end
        if (bus.m_valid && bus.m_ready) begin
          if (q.size() < 3) chk("rnd_underflow", q.size(), 3);
          else begin
            chk("rnd_l1", bus.data_out_1, q.pop_front());
            chk("rnd_l2", bus.data_out_2, q.pop_front());
            chk("rnd_l3", bus.data_out_3, q.pop_front());
          end
          got++;
        end
        held = bus.m_valid && !bus.m_ready;
        p1 = bus.data_out_1;
        p2 = bus.data_out_2;
        p3 = bus.data_out_3;
        @(posedge clk);
        #1;
      end
      chk("rnd_blocks", got, 3333);
      chk("rnd_leftover", q.size(), 0);
    end
    bus.s_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
